// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_BITS data bits (LSB first) then one parity bit.
// Presents the deserialised word and a parity error flag, with a one-cycle done pulse.
`timescale 1ns/1ps
module serial_parity_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 parity_err,
    output logic [DATA_BITS-1:0] data_out
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   shifted;
    logic                   capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            done       <= 1'b0;
            parity_err <= 1'b0;
            data_out   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            done    <= capture;
            if (capture) begin
                parity_err <= acc_q ^ bit_in ^ ODD_PARITY;
                data_out   <= shreg_q;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        shifted = '0;
        capture = 1'b0;

        // start wins in every state: abort/restart with cleared frame state.
        if (start) begin
            state_d = S_DATA;
            acc_d   = 1'b0;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                S_PARITY: if (bit_valid) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end
                S_DONE:   state_d = S_IDLE;
                default:  ;
            endcase
        end

        // A valid bit alongside start is data bit 0 of the new frame.
        if ((start || state_q == S_DATA) && bit_valid) begin
            acc_d                = acc_d ^ bit_in;
            shifted              = shreg_d >> 1;
            shifted[DATA_BITS-1] = bit_in;
            shreg_d              = shifted;
            if (cnt_d == LAST_IDX) state_d = S_PARITY;
            cnt_d = cnt_d + CW'(1);
        end
    end

    assign busy = (state_q == S_DATA) || (state_q == S_PARITY);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even-parity instance plus an odd-parity
// instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       busy, done, parity_err;
    logic [7:0] data_out;
    logic       busy_o, done_o, parity_err_o;
    logic [7:0] data_out_o;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .done(done), .parity_err(parity_err), .data_out(data_out)
    );

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy_o), .done(done_o), .parity_err(parity_err_o), .data_out(data_out_o)
    );

    // Advance one clock and sample 1 ns after the edge; tally done pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic drive(input logic s, input logic v, input logic b);
        start     = s;
        bit_valid = v;
        bit_in    = b;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] word, input int first, input int n);
        for (int i = first; i < n; i++) drive(1'b0, 1'b1, word[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        if ({busy, done, parity_err, data_out} !== 11'd0) begin
            $display("FAIL reset_outputs: got %b, want all zero", {busy, done, parity_err, data_out});
            n_bad++;
        end
        n_cmp++;
        if ({busy_o, done_o, parity_err_o, data_out_o} !== 11'd0) begin
            $display("FAIL reset_outputs_odd: got %b, want all zero",
                     {busy_o, done_o, parity_err_o, data_out_o});
            n_bad++;
        end
        n_cmp++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_even_parity();
        int d0;
        d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0);
        if (busy !== 1'b1) begin
            $display("FAIL even_busy_after_start: got %b want 1", busy); n_bad++;
        end
        n_cmp++;
        send_bits(8'h0D, 0, 8);
        drive(1'b0, 1'b1, 1'b1);
        if (done !== 1'b1 || data_out !== 8'h0D || parity_err !== 1'b0) begin
            $display("FAIL even_frame: done=%b data=%h err=%b want 1 0d 0", done, data_out, parity_err);
            n_bad++;
        end
        n_cmp++;
        tick();
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            $display("FAIL even_done_one_cycle: done=%b busy=%b pulses=%0d want 0 0 1",
                     done, busy, done_cnt - d0);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_bad_parity();
        drive(1'b1, 1'b0, 1'b0);
        send_bits(8'h0D, 0, 8);
        drive(1'b0, 1'b1, 1'b0);
        if (parity_err !== 1'b1 || data_out !== 8'h0D) begin
            $display("FAIL bad_parity_even: err=%b data=%h want 1 0d", parity_err, data_out);
            n_bad++;
        end
        n_cmp++;
        if (parity_err_o !== 1'b0 || data_out_o !== 8'h0D || done_o !== 1'b1) begin
            $display("FAIL odd_parity_ok: err=%b data=%h done=%b want 0 0d 1",
                     parity_err_o, data_out_o, done_o);
            n_bad++;
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_gapped();
        int d0;
        int busy_drops;
        d0 = done_cnt;
        busy_drops = 0;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (busy !== 1'b1) busy_drops++;
            drive(1'b0, 1'b0, 1'b1);
            if (busy !== 1'b1) busy_drops++;
            drive(1'b0, 1'b1, (i < 8) ? 1'b1 : 1'b0);
            if (i < 8 && busy !== 1'b1) busy_drops++;
        end
        if (busy_drops != 0) begin
            $display("FAIL gapped_busy: busy low in %0d cycles, want 0", busy_drops); n_bad++;
        end
        n_cmp++;
        if (data_out !== 8'hFF || parity_err !== 1'b0) begin
            $display("FAIL gapped_frame: data=%h err=%b want ff 0", data_out, parity_err); n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 4; i++) tick();
        if (done_cnt - d0 != 1) begin
            $display("FAIL gapped_single_done: pulses=%0d want 1", done_cnt - d0); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0);
        send_bits(8'h0F, 0, 4);
        drive(1'b1, 1'b0, 1'b0);
        if (busy !== 1'b1 || data_out !== 8'hFF || done_cnt != d0) begin
            $display("FAIL abort_restart: busy=%b data=%h pulses=%0d want 1 ff 0",
                     busy, data_out, done_cnt - d0);
            n_bad++;
        end
        n_cmp++;
        send_bits(8'hA5, 0, 8);
        drive(1'b0, 1'b1, 1'b0);
        tick();
        if (data_out !== 8'hA5 || parity_err !== 1'b0 || done_cnt - d0 != 1) begin
            $display("FAIL abort_frame: data=%h err=%b pulses=%0d want a5 0 1",
                     data_out, parity_err, done_cnt - d0);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b0);
        send_bits(8'hFF, 0, 5);
        #3 rst_n = 1'b0;
        #1;
        if ({busy, done, parity_err, data_out} !== 11'd0) begin
            $display("FAIL async_reset: got %b, want all zero", {busy, done, parity_err, data_out});
            n_bad++;
        end
        n_cmp++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b0);
        send_bits(8'h01, 0, 8);
        drive(1'b0, 1'b1, 1'b1);
        if (data_out !== 8'h01 || parity_err !== 1'b0 || done !== 1'b1) begin
            $display("FAIL post_reset_frame: data=%h err=%b done=%b want 01 0 1",
                     data_out, parity_err, done);
            n_bad++;
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0);
        send_bits(8'h3C, 0, 8);
        drive(1'b0, 1'b1, 1'b0);
        if (done !== 1'b1 || data_out !== 8'h3C || parity_err !== 1'b0) begin
            $display("FAIL b2b_first: done=%b data=%h err=%b want 1 3c 0", done, data_out, parity_err);
            n_bad++;
        end
        n_cmp++;
        // start in the DONE cycle, carrying bit 0 of the next frame
        drive(1'b1, 1'b1, 1'b1);
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_restart: busy=%b done=%b want 1 0", busy, done); n_bad++;
        end
        n_cmp++;
        send_bits(8'h81, 1, 8);
        drive(1'b0, 1'b1, 1'b1);
        if (data_out !== 8'h81 || parity_err !== 1'b1 || done !== 1'b1) begin
            $display("FAIL b2b_second: data=%h err=%b done=%b want 81 1 1", data_out, parity_err, done);
            n_bad++;
        end
        n_cmp++;
        tick();
        tick();
        if (done_cnt - d0 != 2) begin
            $display("FAIL b2b_done_count: pulses=%0d want 2", done_cnt - d0); n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_bad_parity();
        test_gapped();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
